// File: rtl/td4_pkg.sv
// Shared TD4 constants and the program-loader state encoding.
package td4_pkg;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int OPW   = DW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } ld_state_e;
endpackage

// File: rtl/prog_mem.sv
// Single-write, async-read DEPTH x DW array; power-up contents come from INIT.
module prog_mem
  import td4_pkg::*;
#(
  parameter int DEPTH = td4_pkg::DEPTH,
  parameter int AW    = td4_pkg::AW,
  parameter int DW    = td4_pkg::DW,
  parameter logic [DEPTH-1:0][DW-1:0] INIT = '0
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  // No reset on purpose: contents must survive reset_n.
  logic [DEPTH-1:0][DW-1:0] mem_q = INIT;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rom_loader.sv
// TD4 program ROM writer: stages a checksummed 16-byte image, then copies it into the fetch array.
module rom_loader
  import td4_pkg::*;
#(
  parameter int DEPTH   = td4_pkg::DEPTH,
  parameter int AW      = td4_pkg::AW,
  parameter int DW      = td4_pkg::DW,
  parameter int TIMEOUT = 255,
  parameter logic [DEPTH-1:0][DW-1:0] INIT = '0
) (
  input  logic          mclock,
  input  logic          reset_n,
  input  logic          load_req,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          cpu_run,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW:0] IDX_CKS  = (AW+1)'(DEPTH);
  localparam logic [AW:0] IDX_LAST = (AW+1)'(DEPTH-1);
  localparam logic [AW:0] IDX_ONE  = (AW+1)'(1);
  localparam logic [7:0]  TMO_LIM  = 8'(TIMEOUT-1);

  ld_state_e     state_q, state_d;
  logic [AW:0]   idx_q, idx_d;
  logic [DW-1:0] sum_q, sum_d;
  logic [7:0]    tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          stage_we, act_we, accept;
  logic [DW-1:0] stage_rd;

  assign accept = wr_valid && wr_ready;

  always_ff @(posedge mclock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sum_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    stage_we = 1'b0;
    act_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d = LOAD;
          idx_d   = '0;
          sum_d   = '0;
          tmo_d   = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        // An accept always beats a timeout expiring on the same cycle.
        if (accept) begin
          sum_d = sum_q + wr_data;
          tmo_d = '0;
          if (idx_q == IDX_CKS) begin
            state_d = CHECK;
          end else begin
            stage_we = 1'b1;
            idx_d    = idx_q + IDX_ONE;
          end
        end else if (TIMEOUT != 0 && tmo_q >= TMO_LIM) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (tmo_q != 8'hFF) begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      CHECK: begin
        if (sum_q == '0) begin
          state_d = COMMIT;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      COMMIT: begin
        act_we = 1'b1;
        idx_d  = idx_q + IDX_ONE;
        if (idx_q == IDX_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The core only runs from IDLE, so it never fetches a half-copied image.
  assign wr_ready = (state_q == LOAD);
  assign busy     = (state_q != IDLE);
  assign cpu_run  = (state_q == IDLE);
  assign done     = (state_q == COMMIT) && (idx_q == IDX_LAST);
  assign err      = err_q;

  prog_mem #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .INIT('0)) u_stage (
    .clk_i   (mclock),
    .we_i    (stage_we),
    .waddr_i (idx_q[AW-1:0]),
    .wdata_i (wr_data),
    .raddr_i (idx_q[AW-1:0]),
    .rdata_o (stage_rd)
  );

  prog_mem #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .INIT(INIT)) u_active (
    .clk_i   (mclock),
    .we_i    (act_we),
    .waddr_i (idx_q[AW-1:0]),
    .wdata_i (stage_rd),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_rom_loader.sv
// Directed + randomized bench for rom_loader against an image-level reference model.
module tb_rom_loader;
  localparam int TMO = 8;
  localparam logic [15:0][7:0] INIT_IMG = 128'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F;

  logic       mclock = 1'b0;
  logic       reset_n, load_req, wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       cpu_run, busy, done, err;

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0][7:0] act_m;   // expected contents of the fetch image

  always #5 mclock = ~mclock;

  rom_loader #(.TIMEOUT(TMO), .INIT(INIT_IMG)) dut (
    .mclock   (mclock),
    .reset_n  (reset_n),
    .load_req (load_req),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .cpu_run  (cpu_run),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_image(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      chk($sformatf("%s[%0d]", tag, a), {24'd0, rd_data}, {24'd0, act_m[a]});
    end
  endtask

  function automatic logic [7:0] cks_of(input logic [15:0][7:0] img);
    logic [7:0] s = 8'd0;
    for (int i = 0; i < 16; i++) s = s + img[i];
    return 8'd0 - s;
  endfunction

  function automatic int pick_gap(input int mode);
    if (mode == 0) return 0;
    if (mode == 2) return TMO - 1;
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TMO - 1)) : 0;
  endfunction

  task automatic start_load(input string tag);
    @(negedge mclock);
    load_req = 1'b1;
    @(negedge mclock);
    load_req = 1'b0;
    chk({tag, ".run0"}, {31'd0, cpu_run}, 32'd0);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    chk({tag, ".errclr"}, {31'd0, err}, 32'd0);
  endtask

  // Sends n bytes of img (index 16 = checksum byte) with gaps chosen by mode.
  task automatic send_bytes(input string tag, input logic [15:0][7:0] img, input logic [7:0] cks,
                            input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      int g = pick_gap(mode);
      wr_valid = 1'b0;
      for (int j = 0; j < g; j++) begin
        if (mode == 1) load_req = 1'($urandom);
        wr_data = 8'($urandom);
        @(negedge mclock);
      end
      wr_valid = 1'b1;
      wr_data  = (k < 16) ? img[k] : cks;
      #1;
      chk($sformatf("%s.rdy%0d", tag, k), {31'd0, wr_ready}, 32'd1);
      @(negedge mclock);
    end
    wr_valid = 1'b0;
    load_req = 1'b0;
  endtask

  task automatic full_load(input string tag, input logic [15:0][7:0] img, input logic [7:0] adj,
                           input int mode);
    logic [7:0] cks = cks_of(img) + adj;
    bit good = (adj == 8'd0);
    int dn = 0;
    int lat = -1;
    start_load(tag);
    send_bytes(tag, img, cks, 17, mode);
    for (int c = 0; c < 40; c++) begin
      if (done) dn++;
      if (!busy) begin lat = c; break; end
      chk($sformatf("%s.held%0d", tag, c), {31'd0, cpu_run}, 32'd0);
      @(negedge mclock);
    end
    chk({tag, ".lat"}, 32'(lat), good ? 32'd17 : 32'd1);
    chk({tag, ".done"}, 32'(dn), good ? 32'd1 : 32'd0);
    chk({tag, ".err"}, {31'd0, err}, {31'd0, !good});
    chk({tag, ".run1"}, {31'd0, cpu_run}, 32'd1);
    if (good) act_m = img;
    check_image({tag, ".img"});
  endtask

  function automatic logic [15:0][7:0] rand_img();
    logic [15:0][7:0] r;
    for (int i = 0; i < 16; i++) r[i] = 8'($urandom);
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0][7:0] img;
    reset_n  = 1'b0;
    load_req = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'd0;
    rd_addr  = 4'd0;
    act_m    = INIT_IMG;
    repeat (2) @(negedge mclock);
    reset_n = 1'b1;
    @(negedge mclock);

    chk("rst.run", {31'd0, cpu_run}, 32'd1);
    chk("rst.rdy", {31'd0, wr_ready}, 32'd0);
    chk("rst.err", {31'd0, err}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    check_image("rst.img");

    for (int i = 0; i < 16; i++) img[i] = (i == 0) ? 8'h30 : 8'(i);
    full_load("good", img, 8'd0, 0);

    full_load("badck", rand_img(), 8'd1, 1);

    for (int r = 0; r < 3; r++) full_load($sformatf("rnd%0d", r), rand_img(), 8'd0, 1);

    // Every gap is one cycle short of expiry, so the accept must win each time.
    full_load("maxgap", rand_img(), 8'd0, 2);

    img = rand_img();
    start_load("tmo");
    send_bytes("tmo", img, 8'd0, 5, 0);
    repeat (TMO - 1) @(negedge mclock);
    chk("tmo.alive", {31'd0, busy}, 32'd1);
    @(negedge mclock);
    chk("tmo.busy", {31'd0, busy}, 32'd0);
    chk("tmo.err", {31'd0, err}, 32'd1);
    chk("tmo.run", {31'd0, cpu_run}, 32'd1);
    check_image("tmo.img");
    full_load("retry", rand_img(), 8'd0, 1);

    img = rand_img();
    start_load("rstld");
    send_bytes("rstld", img, 8'd0, 7, 1);
    reset_n = 1'b0;
    #1;
    chk("rstld.busy", {31'd0, busy}, 32'd0);
    chk("rstld.run", {31'd0, cpu_run}, 32'd1);
    chk("rstld.rdy", {31'd0, wr_ready}, 32'd0);
    @(negedge mclock);
    reset_n = 1'b1;
    @(negedge mclock);
    chk("rstld.err", {31'd0, err}, 32'd0);
    check_image("rstld.img");

    img = rand_img();
    start_load("rstcm");
    send_bytes("rstcm", img, cks_of(img), 17, 0);
    repeat (6) @(negedge mclock);
    chk("rstcm.mid", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rstcm.busy", {31'd0, busy}, 32'd0);
    chk("rstcm.run", {31'd0, cpu_run}, 32'd1);
    chk("rstcm.err", {31'd0, err}, 32'd0);
    @(negedge mclock);
    reset_n = 1'b1;
    full_load("reload", rand_img(), 8'd0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
